// File: rtl/bip_pkg.sv
// Constants and encodings shared by the BIP control unit and the BIP datapath.
package bip_pkg;

  localparam int NB_DATA          = 16;
  localparam int NB_OPERAND       = 11;
  localparam int N_DATA_ADDR      = 1024;
  localparam int LOG2_N_DATA_ADDR = 10;
  localparam int NB_SEL_A         = 2;
  localparam int NB_COUNT         = 32;

  typedef enum logic [1:0] {
    SEL_A_MEM  = 2'b00,
    SEL_A_IMM  = 2'b01,
    SEL_A_ALU  = 2'b10,
    SEL_A_RSVD = 2'b11
  } sel_a_e;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/bip_data_mem.sv
// BIP data memory: one synchronous write port, asynchronous execution and debug read ports.
module bip_data_mem
  import bip_pkg::*;
#(
  parameter int NB_WORD = bip_pkg::NB_DATA,
  parameter int N_WORDS = bip_pkg::N_DATA_ADDR,
  parameter int NB_ADDR = bip_pkg::LOG2_N_DATA_ADDR
) (
  input  logic               clock,
  input  logic               we,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_WORD-1:0] wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_WORD-1:0] rd_data,
  input  logic [NB_ADDR-1:0] dbg_addr,
  output logic [NB_WORD-1:0] dbg_data
);

  logic [NB_WORD-1:0] mem [N_WORDS];

  // Contents are deliberately never reset.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data  = mem[rd_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, add/subtract ALU, data memory, sticky fault flags
// and a saturating executed-instruction counter, all advancing on valid cycles.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int NB_DATA          = bip_pkg::NB_DATA,
  parameter int NB_OPERAND       = bip_pkg::NB_OPERAND,
  parameter int N_DATA_ADDR      = bip_pkg::N_DATA_ADDR,
  parameter int LOG2_N_DATA_ADDR = bip_pkg::LOG2_N_DATA_ADDR,
  parameter int NB_SEL_A         = bip_pkg::NB_SEL_A,
  parameter int NB_COUNT         = bip_pkg::NB_COUNT
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [NB_SEL_A-1:0]         i_sel_a,
  input  logic                        i_sel_b,
  input  logic                        i_wr_acc,
  input  logic                        i_op_code,
  input  logic                        i_wr_ram,
  input  logic                        i_rd_ram,
  input  logic [NB_OPERAND-1:0]       i_operand,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]          o_acc,
  output logic [NB_DATA-1:0]          o_dbg_data,
  output logic                        o_ovf,
  output logic                        o_addr_fault,
  output logic [NB_COUNT-1:0]         o_exec_count
);

  function automatic logic signed_ovf(input logic                      add,
                                      input logic signed [NB_DATA-1:0] a,
                                      input logic signed [NB_DATA-1:0] b,
                                      input logic signed [NB_DATA-1:0] r);
    if (add) return (a[NB_DATA-1] == b[NB_DATA-1]) && (r[NB_DATA-1] != a[NB_DATA-1]);
    return (a[NB_DATA-1] != b[NB_DATA-1]) && (r[NB_DATA-1] != a[NB_DATA-1]);
  endfunction

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] c);
    return (&c) ? c : c + NB_COUNT'(1);
  endfunction

  logic                        vld_p0;
  logic [LOG2_N_DATA_ADDR-1:0] addr_p0;
  logic                        oor_p0;
  logic                        we_p0;
  logic signed [NB_DATA-1:0]   imm_p0;
  logic signed [NB_DATA-1:0]   mem_rd_p0;
  logic signed [NB_DATA-1:0]   mem_q_p0;
  logic signed [NB_DATA-1:0]   b_p0;
  logic signed [NB_DATA-1:0]   alu_p0;
  logic signed [NB_DATA-1:0]   dbg_rd;

  logic signed [NB_DATA-1:0]   acc_p1;
  logic                        ovf_p1;
  logic                        fault_p1;
  logic [NB_COUNT-1:0]         count_p1;

  // Stage p0: decode operand, read memory, compute ALU result
  assign vld_p0    = i_valid;
  assign addr_p0   = i_operand[LOG2_N_DATA_ADDR-1:0];
  assign oor_p0    = i_operand[NB_OPERAND-1];
  assign imm_p0    = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  assign mem_q_p0  = (i_rd_ram && !oor_p0) ? mem_rd_p0 : '0;
  assign b_p0      = i_sel_b ? imm_p0 : mem_q_p0;
  assign alu_p0    = (i_op_code == OP_ADD) ? acc_p1 + b_p0 : acc_p1 - b_p0;
  // A reset present at the edge must also block the store, since the memory is not reset.
  assign we_p0     = vld_p0 & i_wr_ram & ~oor_p0 & ~i_reset;

  bip_data_mem #(
    .NB_WORD (NB_DATA),
    .N_WORDS (N_DATA_ADDR),
    .NB_ADDR (LOG2_N_DATA_ADDR)
  ) u_mem (
    .clock    (i_clock),
    .we       (we_p0),
    .wr_addr  (addr_p0),
    .wr_data  (acc_p1),
    .rd_addr  (addr_p0),
    .rd_data  (mem_rd_p0),
    .dbg_addr (i_dbg_addr),
    .dbg_data (dbg_rd)
  );

  // Stage p1: architectural state
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc_p1   <= '0;
      ovf_p1   <= 1'b0;
      fault_p1 <= 1'b0;
      count_p1 <= '0;
    end else if (vld_p0) begin
      if (i_wr_acc) begin
        case (sel_a_e'(i_sel_a))
          SEL_A_MEM: acc_p1 <= mem_q_p0;
          SEL_A_IMM: acc_p1 <= imm_p0;
          SEL_A_ALU: acc_p1 <= alu_p0;
          default:   acc_p1 <= acc_p1;
        endcase
      end
      if (i_wr_acc && (sel_a_e'(i_sel_a) == SEL_A_ALU) &&
          signed_ovf(i_op_code == OP_ADD, acc_p1, b_p0, alu_p0))
        ovf_p1 <= 1'b1;
      if ((i_rd_ram || i_wr_ram) && oor_p0)
        fault_p1 <= 1'b1;
      if (i_wr_acc || i_wr_ram)
        count_p1 <= sat_inc(count_p1);
    end
  end

  assign o_acc        = acc_p1;
  assign o_dbg_data   = dbg_rd;
  assign o_ovf        = ovf_p1;
  assign o_addr_fault = fault_p1;
  assign o_exec_count = count_p1;

endmodule
